// File: rtl/seg_scan_pkg.sv
// Shared constants and types for the seven-segment scan decoder.
// Segment codes are active-high, bit 6 = segment A down to bit 0 = segment G.
package seg_scan_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int DIGIT_W    = 4;

    localparam logic [6:0] SEG_0 = 7'b1111110;
    localparam logic [6:0] SEG_1 = 7'b0110000;
    localparam logic [6:0] SEG_2 = 7'b1101101;
    localparam logic [6:0] SEG_3 = 7'b1111001;
    localparam logic [6:0] SEG_4 = 7'b0110011;
    localparam logic [6:0] SEG_5 = 7'b1011011;
    localparam logic [6:0] SEG_6 = 7'b1011111;
    localparam logic [6:0] SEG_7 = 7'b1110000;
    localparam logic [6:0] SEG_8 = 7'b1111111;
    localparam logic [6:0] SEG_9 = 7'b1111011;
    localparam logic [6:0] SEG_A = 7'b1110111;
    localparam logic [6:0] SEG_B = 7'b0011111;
    localparam logic [6:0] SEG_C = 7'b1001110;
    localparam logic [6:0] SEG_D = 7'b0111101;
    localparam logic [6:0] SEG_E = 7'b1001111;
    localparam logic [6:0] SEG_F = 7'b1000111;

    typedef enum logic [1:0] {
        WAIT  = 2'd0,
        CHECK = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/seg_scan_decoder_seg7.sv
// Combinational seven-segment to hex decoder; flags codes outside the 0..F set.
module seg7_to_hex
    import seg_scan_pkg::*;
(
    input  logic [6:0]         code,
    output logic [DIGIT_W-1:0] value,
    output logic               legal
);

    always_comb begin
        value = '0;
        legal = 1'b1;
        case (code)
            SEG_0:   value = 4'h0;
            SEG_1:   value = 4'h1;
            SEG_2:   value = 4'h2;
            SEG_3:   value = 4'h3;
            SEG_4:   value = 4'h4;
            SEG_5:   value = 4'h5;
            SEG_6:   value = 4'h6;
            SEG_7:   value = 4'h7;
            SEG_8:   value = 4'h8;
            SEG_9:   value = 4'h9;
            SEG_A:   value = 4'hA;
            SEG_B:   value = 4'hB;
            SEG_C:   value = 4'hC;
            SEG_D:   value = 4'hD;
            SEG_E:   value = 4'hE;
            SEG_F:   value = 4'hF;
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Passive monitor recovering eight hex digits from a multiplexed 7-segment bus.
// Optional macro SEG_SCAN_ERR_COUNT_EN adds a saturating 8-bit err_count output.
module seg_scan_decoder
    import seg_scan_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               segA,
    input  logic               segB,
    input  logic               segC,
    input  logic               segD,
    input  logic               segE,
    input  logic               segF,
    input  logic               segG,
    input  logic               an0,
    input  logic               an1,
    input  logic               an2,
    input  logic               an3,
    input  logic               an4,
    input  logic               an5,
    input  logic               an6,
    input  logic               an7,
    input  logic [2:0]         sel,
    output logic [DIGIT_W-1:0] num,
    output logic               num_valid,
    output logic               cap_pulse,
    output logic [2:0]         cap_sel,
    output logic               frame_done,
    output logic               err_pulse
`ifdef SEG_SCAN_ERR_COUNT_EN
    ,
    output logic [7:0]         err_count
`endif
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_FIRE = CNT_W'(STABLE_CYCLES - 1);

    logic [14:0]           bus_raw;
    logic [14:0]           sync1_reg;
    logic [14:0]           sync2_reg;
    logic [14:0]           snap_reg;
    logic [CNT_W-1:0]      cnt_reg;
    state_t                state_reg;
    logic [NUM_DIGITS-1:0] valid_reg;
    logic [NUM_DIGITS-1:0] seen_reg;
    logic                  cap_pulse_reg;
    logic                  err_pulse_reg;
    logic                  frame_done_reg;
    logic [2:0]            cap_sel_reg;

    logic                  changed;
    logic [6:0]            snap_code;
    logic [NUM_DIGITS-1:0] snap_an;
    logic [DIGIT_W-1:0]    seg_value;
    logic                  seg_legal;
    logic                  one_hot;
    logic [2:0]            idx;
    logic                  cap_wr;
    logic                  bad_seg;
    logic                  multi;
    logic                  seen_full;
    logic [NUM_DIGITS-1:0] cap_mask;
    logic [DIGIT_W-1:0]    digit_q [NUM_DIGITS];

    assign bus_raw = {segA, segB, segC, segD, segE, segF, segG,
                      an7, an6, an5, an4, an3, an2, an1, an0};

    // Looking at the sample about to enter sync2 lets cnt count the cycles the
    // synchronized vector has already held, so the window ends S cycles in.
    assign changed = (sync1_reg != sync2_reg);

    // The stable pattern is snapshotted on entry to CHECK, so a change landing
    // right at the end of the window cannot corrupt the classification.
    assign snap_code = ~snap_reg[14:8];
    assign snap_an   = ~snap_reg[7:0];

    seg7_to_hex u_dec (
        .code  (snap_code),
        .value (seg_value),
        .legal (seg_legal)
    );

    always_comb begin
        idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (snap_an[i]) idx = 3'(i);
        end
    end

    assign one_hot   = (snap_an != '0) && ((snap_an & (snap_an - 1'b1)) == '0);
    assign cap_wr    = (state_reg == CHECK) && one_hot && seg_legal;
    assign bad_seg   = (state_reg == CHECK) && one_hot && !seg_legal;
    assign multi     = (state_reg == CHECK) && !one_hot && (snap_an != '0);
    assign seen_full = &seen_reg;
    assign cap_mask  = cap_wr ? (NUM_DIGITS'(1) << idx) : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_reg      <= '1;
            sync2_reg      <= '1;
            snap_reg       <= '1;
            cnt_reg        <= '0;
            state_reg      <= WAIT;
            valid_reg      <= '0;
            seen_reg       <= '0;
            cap_pulse_reg  <= 1'b0;
            err_pulse_reg  <= 1'b0;
            frame_done_reg <= 1'b0;
            cap_sel_reg    <= '0;
        end else begin
            sync1_reg <= bus_raw;
            sync2_reg <= sync1_reg;

            if (changed)
                cnt_reg <= '0;
            else if (cnt_reg != CNT_MAX)
                cnt_reg <= cnt_reg + 1'b1;

            cap_pulse_reg  <= cap_wr;
            err_pulse_reg  <= bad_seg || multi;
            frame_done_reg <= seen_full;
            seen_reg       <= (seen_full ? '0 : seen_reg) | cap_mask;

            if (cap_wr) begin
                valid_reg[idx] <= 1'b1;
                cap_sel_reg    <= idx;
            end else if (bad_seg) begin
                valid_reg[idx] <= 1'b0;
            end

            case (state_reg)
                WAIT: begin
                    if (cnt_reg == CNT_FIRE) begin
                        state_reg <= CHECK;
                        snap_reg  <= sync2_reg;
                    end
                end
                CHECK: begin
                    // A new pattern already under way must get its own window.
                    if (changed || (sync2_reg != snap_reg))
                        state_reg <= WAIT;
                    else
                        state_reg <= HOLD;
                end
                HOLD: begin
                    if (changed) state_reg <= WAIT;
                end
                default: state_reg <= WAIT;
            endcase
        end
    end

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        logic [DIGIT_W-1:0] digit_reg;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset)
                digit_reg <= '0;
            else if (cap_wr && (idx == 3'(gi)))
                digit_reg <= seg_value;
        end

        assign digit_q[gi] = digit_reg;
    end

`ifdef SEG_SCAN_ERR_COUNT_EN
    logic [7:0] err_count_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            err_count_reg <= '0;
        else if ((bad_seg || multi) && (err_count_reg != 8'hFF))
            err_count_reg <= err_count_reg + 8'd1;
    end

    assign err_count = err_count_reg;
`endif

    assign num        = digit_q[sel];
    assign num_valid  = valid_reg[sel];
    assign cap_pulse  = cap_pulse_reg;
    assign err_pulse  = err_pulse_reg;
    assign frame_done = frame_done_reg;
    assign cap_sel    = cap_sel_reg;

endmodule
